// File: rtl/usr_pkg.sv
// Shared types for the universal shift register command sequencer.
// Holds the command record, the mode encoding and the FSM states.
package usr_pkg;

  localparam int USR_WIDTH      = 4;
  localparam int USR_CNT_W      = 4;
  localparam int USR_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e                op;
    logic [USR_WIDTH-1:0] data;
    logic [USR_CNT_W-1:0] count;
  } cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/usr_cmd_fifo.sv
// Small synchronous command FIFO.
// Pointers carry one extra wrap bit to tell full from empty.
module usr_cmd_fifo
  import usr_pkg::*;
#(
  parameter int DEPTH = USR_FIFO_DEPTH
) (
  input  logic clock,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t        mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rp[AW-1:0]];

  // Pointer update; flush wins over push and pop.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // Storage write on an accepted push.
  always_ff @(posedge clock) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Replays queued commands onto the shift register mode/data_in pins.
// Each command drives count+1 cycles, LOAD always exactly one.
module usr_cmd_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH      = USR_WIDTH,
  parameter int FIFO_DEPTH = USR_FIFO_DEPTH,
  parameter int CNT_W      = USR_CNT_W
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             flush,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic [CNT_W-1:0] remaining;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             take;
  cmd_t             wcmd;
  cmd_t             head;

  assign cmd_ready = rst && !fifo_full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign take      = !flush && !fifo_empty &&
                     ((state == IDLE) || (remaining == '0));
  assign busy      = (state == RUN) || !fifo_empty;

  assign wcmd.op    = mode_e'(cmd_op);
  assign wcmd.data  = cmd_data;
  assign wcmd.count = cmd_count;

  usr_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push),
    .pop   (take),
    .flush (flush),
    .wdata (wcmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM, repeat counter and registered pin drivers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      mode      <= HOLD;
      data_in   <= '0;
      done      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      remaining <= '0;
      mode      <= HOLD;
      done      <= 1'b0;
    end else if (take) begin
      state     <= RUN;
      mode      <= head.op;
      data_in   <= head.data;
      if (head.op == LOAD) begin
        remaining <= '0;
        done      <= 1'b1;
      end else begin
        remaining <= head.count;
        done      <= (head.count == '0);
      end
    end else if ((state == RUN) && (remaining != '0)) begin
      remaining <= remaining - CNT_W'(1);
      done      <= (remaining == CNT_W'(1));
    end else begin
      state <= IDLE;
      mode  <= HOLD;
      done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed bench for the command sequencer.
// Vector table plus hand sequences for full, flush, count and reset.
module tb_usr_cmd_sequencer;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'h0;
  logic [3:0] cmd_count = 4'h0;
  logic       flush = 1'b0;
  logic [1:0] mode;
  logic [3:0] data_in;
  logic       busy;
  logic       done;
  logic [3:0] sreg;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  usr_cmd_sequencer dut (
    .clock     (clock),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .flush     (flush),
    .mode      (mode),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done)
  );

  // Downstream shift register model fed by the sequencer.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) sreg <= 4'h0;
    else begin
      case (mode)
        2'b01:   sreg <= {1'b0, sreg[3:1]};
        2'b10:   sreg <= {sreg[2:0], 1'b0};
        2'b11:   sreg <= data_in;
        default: sreg <= sreg;
      endcase
    end
  end

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] d;
    logic [3:0] c;
    logic [1:0] em;
    logic [3:0] ed;
    logic       edn;
    logic       eb;
    logic       er;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(
    input logic v, input logic [1:0] op,
    input logic [3:0] d, input logic [3:0] c,
    input logic [1:0] em, input logic [3:0] ed,
    input logic edn, input logic eb, input logic er);
    vec_t r;
    r.v = v; r.op = op; r.d = d; r.c = c;
    r.em = em; r.ed = ed; r.edn = edn;
    r.eb = eb; r.er = er;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [3:0] d, input logic [3:0] c,
                       input logic fl);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = c;
    flush     = fl;
  endtask

  task automatic nxt();
    @(negedge clock);
    #1;
  endtask

  logic [1:0] fops [5];

  initial begin
    // back-to-back SHL x3 then SHR x1, then a single LOAD
    vecs[0]  = mk(1, 2'b10, 4'h3, 4'd2, 2'b00, 4'h0, 0, 0, 1);
    vecs[1]  = mk(1, 2'b01, 4'hC, 4'd0, 2'b00, 4'h0, 0, 1, 1);
    vecs[2]  = mk(0, 2'b00, 4'h0, 4'd0, 2'b10, 4'h3, 0, 1, 1);
    vecs[3]  = mk(0, 2'b00, 4'h0, 4'd0, 2'b10, 4'h3, 0, 1, 1);
    vecs[4]  = mk(0, 2'b00, 4'h0, 4'd0, 2'b10, 4'h3, 1, 1, 1);
    vecs[5]  = mk(0, 2'b00, 4'h0, 4'd0, 2'b01, 4'hC, 1, 1, 1);
    vecs[6]  = mk(0, 2'b00, 4'h0, 4'd0, 2'b00, 4'hC, 0, 0, 1);
    vecs[7]  = mk(1, 2'b11, 4'hA, 4'd5, 2'b00, 4'hC, 0, 0, 1);
    vecs[8]  = mk(0, 2'b00, 4'h0, 4'd0, 2'b00, 4'hC, 0, 1, 1);
    vecs[9]  = mk(0, 2'b00, 4'h0, 4'd0, 2'b11, 4'hA, 1, 1, 1);
    vecs[10] = mk(0, 2'b00, 4'h0, 4'd0, 2'b00, 4'hA, 0, 0, 1);

    // reset state, asserted from time zero
    #1;
    chk("rst_mode", mode, 2'b00);
    chk("rst_din", data_in, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    @(negedge clock);
    rst = 1'b1;
    #1;
    chk("rel_ready", cmd_ready, 1'b1);

    // table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].d, vecs[i].c, 1'b0);
      #1;
      chk($sformatf("v%0d_mode", i), mode, vecs[i].em);
      chk($sformatf("v%0d_din", i), data_in, vecs[i].ed);
      chk($sformatf("v%0d_done", i), done, vecs[i].edn);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].eb);
      chk($sformatf("v%0d_ready", i), cmd_ready, vecs[i].er);
      nxt();
    end
    chk("load_sreg", sreg, 4'hA);

    // full: five count=15 commands while the first runs
    fops[0] = 2'b01; fops[1] = 2'b10; fops[2] = 2'b00;
    fops[3] = 2'b01; fops[4] = 2'b10;
    for (int c = 0; c < 5; c++) begin
      drive(1, fops[c], 4'(c + 1), 4'd15, 0);
      #1;
      chk($sformatf("full_push%0d_ready", c), cmd_ready, 1'b1);
      nxt();
    end
    drive(0, 0, 0, 0, 0);
    #1;
    chk("full_ready_low", cmd_ready, 1'b0);
    for (int c = 0; c < 5; c++) begin
      for (int k = (c == 0) ? 3 : 0; k < 16; k++) begin
        chk($sformatf("full_c%0d_k%0d_mode", c, k), mode, fops[c]);
        chk($sformatf("full_c%0d_k%0d_din", c, k),
            data_in, 4'(c + 1));
        chk($sformatf("full_c%0d_k%0d_done", c, k),
            done, (k == 15));
        if (c == 0 && k == 15)
          chk("full_ready_before_pop", cmd_ready, 1'b0);
        if (c == 1 && k == 0)
          chk("full_ready_after_pop", cmd_ready, 1'b1);
        nxt();
      end
    end
    chk("full_end_mode", mode, 2'b00);
    chk("full_end_busy", busy, 1'b0);

    // flush: SHR count=8 with two queued, flush at its third cycle
    drive(1, 2'b01, 4'h9, 4'd8, 0);
    nxt();
    drive(1, 2'b11, 4'hF, 4'd0, 0);
    nxt();
    drive(1, 2'b10, 4'h6, 4'd1, 0);
    nxt();
    drive(0, 0, 0, 0, 0);
    nxt();
    chk("fl_pre_mode", mode, 2'b01);
    chk("fl_pre_busy", busy, 1'b1);
    drive(1, 2'b11, 4'h1, 4'd0, 1);
    #1;
    chk("fl_ready_low", cmd_ready, 1'b0);
    nxt();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("fl_mode", mode, 2'b00);
    chk("fl_done", done, 1'b0);
    chk("fl_busy", busy, 1'b0);
    for (int k = 0; k < 12; k++) begin
      nxt();
      chk($sformatf("fl_after%0d_mode", k), mode, 2'b00);
      chk($sformatf("fl_after%0d_done", k), done, 1'b0);
    end

    // max count: HOLD count=15 runs 16 cycles
    drive(1, 2'b00, 4'h5, 4'd15, 0);
    nxt();
    drive(0, 0, 0, 0, 0);
    nxt();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("max_k%0d_mode", k), mode, 2'b00);
      chk($sformatf("max_k%0d_din", k), data_in, 4'h5);
      chk($sformatf("max_k%0d_done", k), done, (k == 15));
      chk($sformatf("max_k%0d_busy", k), busy, 1'b1);
      nxt();
    end
    chk("max_end_done", done, 1'b0);
    chk("max_end_busy", busy, 1'b0);

    // reset in the middle of a SHR command
    drive(1, 2'b01, 4'h7, 4'd8, 0);
    nxt();
    drive(0, 0, 0, 0, 0);
    nxt();
    nxt();
    chk("mid_mode_pre", mode, 2'b01);
    rst = 1'b0;
    #1;
    chk("mid_rst_mode", mode, 2'b00);
    chk("mid_rst_din", data_in, 4'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b0);
    @(negedge clock);
    rst = 1'b1;
    #1;
    chk("mid_rel_ready", cmd_ready, 1'b1);
    nxt();
    chk("mid_rel_busy", busy, 1'b0);
    chk("mid_rel_mode", mode, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usr_cmd_sequencer.md
Name: usr_cmd_sequencer

Overview:
Upstream driver for the 4-bit universal shift register. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It then replays each command onto the register's mode/data_in pins for a programmed number of clock cycles. Its registered outputs connect directly to the shift register's mode and data_in inputs.

Parameters:
WIDTH, 4, data width; matches shift register data_in/data_out
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
CNT_W, 4, width of repeat-count field

Ports:
clock  input  1  single clock, all logic on posedge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; handshake completes when valid&&ready at posedge
cmd_op  input  2  00 HOLD, 01 SHIFT_RIGHT, 10 SHIFT_LEFT, 11 LOAD
cmd_data  input  WIDTH  value driven on data_in for the command's duration
cmd_count  input  CNT_W  extra cycles; command drives count+1 cycles (ignored for LOAD)
flush  input  1  synchronous abort: empty FIFO, terminate current command
mode  output  2  to shift register mode
data_in  output  WIDTH  to shift register data_in
busy  output  1  FSM in RUN or FIFO non-empty
done  output  1  high during the last driven cycle of each completed command

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (ports named clock and rst).
- Reset (rst=0, immediate, no clock needed):
  - mode=00, data_in=0, busy=0, done=0.
  - FIFO empty; FSM state IDLE.
  - cmd_ready=0 while rst=0.
- cmd_ready = rst && !fifo_full && !flush (combinational).
  - A pop in the same cycle does not free a slot for a same-cycle push.
- FSM states: IDLE, RUN. mode, data_in and done are registered.
- IDLE:
  - FIFO empty: mode=00, data_in holds its last value.
  - FIFO non-empty at an edge: pop the head; load mode=op and data_in=data; load remaining = (op==LOAD) ? 0 : count; go to RUN.
- RUN, each edge:
  - remaining>0: decrement; mode/data_in unchanged.
  - remaining==0 (last cycle just driven): if FIFO non-empty, pop the next command back-to-back with no HOLD bubble; else mode=00 and go to IDLE.
- done=1 exactly in the cycle where RUN and remaining==0; one pulse per command. A LOAD produces mode=11 for 1 cycle with done=1.
- Latency: push at edge k with FSM IDLE and FIFO empty -> mode/data_in valid after edge k+1.
- Count boundaries:
  - cmd_count = 2^CNT_W-1 (15) gives 16 cycles; remaining never wraps.
  - cmd_count=0 gives 1 cycle.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty are derived from MSB comparison.
- flush=1 at an edge:
  - FIFO cleared; FSM to IDLE; mode=00 next cycle; done=0 (an aborted command gives no done).
  - A push attempted in the same cycle is dropped (ready is low).
  - flush takes priority over pop.
- rst asserted mid-command: outputs go to reset values immediately; all queued commands are lost.
- busy = (state==RUN) || !fifo_empty, combinational from registers.

Decomposition:
- Package usr_pkg:
  - mode_e enum {HOLD=2'b00, SHR=2'b01, SHL=2'b10, LOAD=2'b11}
  - cmd_t packed struct {mode_e op; logic[WIDTH-1:0] data; logic[CNT_W-1:0] count}
  - state_e {IDLE, RUN}
  - default WIDTH/CNT_W constants
- Sub-module usr_cmd_fifo: synchronous FIFO of cmd_t with push, pop, flush, full, empty, async active-low rst. The sequencer holds only the FSM, counter and output registers.

Test Plan:
- Reset: hold rst=0 mid-RUN of a SHR command -> mode=00, data_in=0, busy=0, done=0, cmd_ready=0 immediately. After release, cmd_ready=1.
- Single LOAD: push op=11, data=4'hA, count=5 into an idle block -> one cycle of mode=11 with data_in=A and done=1, then mode=00. Downstream data_out becomes A.
- Back-to-back: push SHL count=2, then SHR count=0 -> mode=10 for exactly 3 cycles (done on the 3rd), then mode=01 for 1 cycle with done=1, then 00. No HOLD gap.
- Full: push 5 commands with count=15 while the FSM runs -> cmd_ready drops after 4 entries (FIFO full; the head is in RUN). ready reasserts the cycle after a pop. All 5 execute in order.
- Flush: during SHR count=8 at cycle 3, with 2 commands queued, pulse flush -> mode=00 next cycle, no done, busy=0, queued commands never appear.
- Max count: HOLD count=15 with data=4'h5 -> mode=00, data_in=5 for 16 cycles, done on the 16th, no wrap to an extra cycle.
